keypad_reader: RTL
==================

KEYPAD_READER -- requirements
Module: keypad_reader

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per scan tick (min 2).
REQ-002 SHALL have parameter DEB_CNT, default 20, consecutive scan ticks required for press and for release (min 1).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low, one-cold.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse per debounced press.
REQ-008 SHALL have port key_code  output  4  code of the last debounced press.
REQ-009 SHALL have port key_held  output  1  high from the press pulse until release is confirmed.
REQ-010 SHALL have port operand  output  8  binary operand 0..99 (REQ-027).
REQ-011 SHALL have port op_valid  output  1  one-cycle operand-load pulse (REQ-027).

Function
REQ-012 SHALL pass row through a 2-flop synchronizer; all decisions use synchronized rows.
REQ-013 SHALL generate a one-cycle scan tick every SCAN_DIV clk cycles from a free-running divider.
REQ-014 SHALL implement FSM states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-015 SCAN: on each tick, if any synced row is low, SHALL latch column index and lowest-index low row, clear debounce count, go DEBOUNCE; else rotate col 1110->1101->1011->0111->1110.
REQ-016 DEBOUNCE: col frozen; on each tick, if latched row still low, SHALL increment count and go PRESSED when count reaches DEB_CNT; if latched row is high, SHALL return to SCAN, resume rotation from the next column.
REQ-017 PRESSED: SHALL last exactly one cycle, assert key_valid, update key_code, clear count, go RELEASE.
REQ-018 RELEASE: col frozen; on each tick, if all four synced rows high, count increments, else count clears; at count == DEB_CNT SHALL go SCAN.
REQ-019 key_code map (row,col): (0,0..3)=1,2,3,A; (1,*)=4,5,6,B; (2,*)=7,8,9,C; (3,*)='*'=E,0,'#'=F,D; digits encode their value.
REQ-020 Multiple rows low in one column SHALL resolve to the lowest row index; other columns SHALL NOT be sampled until return to SCAN.
REQ-021 key_held SHALL be high in PRESSED and RELEASE, low otherwise.
REQ-022 A held key SHALL produce exactly one key_valid; no auto-repeat.
REQ-023 Press-to-pulse latency SHALL be DEB_CNT ticks after the detecting tick plus one cycle, plus the synchronizer delay.

Reset
REQ-024 rst_n low SHALL asynchronously force state SCAN, col=1110, divider and counts 0, key_valid=0, key_code=0, key_held=0, operand=0, op_valid=0, synchronizer flops 1.
REQ-025 Reset asserted mid-debounce or mid-release SHALL discard the pending key; no key_valid after reset release until a fresh full debounce.
REQ-026 First scan tick after reset release SHALL occur SCAN_DIV cycles later.

Configuration
REQ-027 With macro KEYPAD_OPERAND_EN defined: two BCD digit registers (tens, units); digit key (0..9) pulse shifts units->tens, new digit->units; '*' clears both; '#' pulses op_valid one cycle after its key_valid; A-D ignored; operand = tens*10+units; a third digit discards the oldest.
REQ-028 Without KEYPAD_OPERAND_EN: no digit registers; operand tied 0, op_valid tied 0; all other behaviour identical.

Verification (SCAN_DIV=4, DEB_CNT=3)
REQ-029 Reset release, rows 1111 -> col cycles 1110,1101,1011,0111 every 4 clk; key_valid never asserts.
REQ-030 Key '5' (row1 low while col=1101) held 40 cycles -> one key_valid, key_code=5, key_held high until 3 ticks after release.
REQ-031 Row0 low for 2 ticks then high -> no key_valid; FSM returns to SCAN; col resumes rotation.
REQ-032 Rows 0 and 2 low together in col0 -> key_code=1.
REQ-033 rst_n pulsed low during DEBOUNCE -> outputs at reset values immediately; no key_valid.
REQ-034 KEYPAD_OPERAND_EN: keys 4,2,# -> op_valid pulse with operand=42; then 7,3,9,# -> operand=39; '*' -> operand=0.

Source files
------------

// File: rtl/keypad_reader.sv
// keypad_reader: 4x4 matrix keypad scanner with press/release debounce.
// Define KEYPAD_OPERAND_EN to add two-digit BCD operand entry (0..99).
module keypad_reader #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic [7:0] operand,
    output logic       op_valid
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_CNT + 1);
    // nibble {row,col} holds the code for that key position
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        r_state, w_state;
    logic [3:0]    r_row_m, r_row_s;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
    logic [1:0]    r_col_idx, w_col_idx, r_row_idx, w_row_idx, w_low_row;
    logic [3:0]    r_key_code;
    logic          w_tick;

    assign w_tick    = r_div == DW'(SCAN_DIV - 1);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_low_row = !r_row_s[0] ? 2'd0 : !r_row_s[1] ? 2'd1 : !r_row_s[2] ? 2'd2 : 2'd3;
    assign col       = ~(4'b0001 << r_col_idx);
    assign key_valid = r_state == PRESSED;
    assign key_held  = r_state == PRESSED || r_state == RELEASE;
    assign key_code  = r_key_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_m    <= 4'hF;
            r_row_s    <= 4'hF;
            r_div      <= '0;
            r_state    <= SCAN;
            r_cnt      <= '0;
            r_col_idx  <= 2'd0;
            r_row_idx  <= 2'd0;
            r_key_code <= 4'h0;
        end else begin
            r_row_m    <= row;
            r_row_s    <= r_row_m;
            r_div      <= w_tick ? '0 : r_div + 1'b1;
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_col_idx  <= w_col_idx;
            r_row_idx  <= w_row_idx;
            r_key_code <= (r_state == DEBOUNCE && w_state == PRESSED) ?
                          KEYMAP[{r_row_idx, r_col_idx, 2'b00} +: 4] : r_key_code;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_col_idx = r_col_idx;
        w_row_idx = r_row_idx;
        case (r_state)
            SCAN: if (w_tick) begin
                if (r_row_s != 4'hF) begin
                    w_row_idx = w_low_row;
                    w_cnt     = '0;
                    w_state   = DEBOUNCE;
                end else begin
                    w_col_idx = r_col_idx + 2'd1;
                end
            end
            DEBOUNCE: if (w_tick) begin
                if (!r_row_s[r_row_idx]) begin
                    w_cnt   = w_cnt_inc;
                    w_state = (w_cnt_inc == CW'(DEB_CNT)) ? PRESSED : DEBOUNCE;
                end else begin
                    w_state   = SCAN;
                    w_col_idx = r_col_idx + 2'd1;
                end
            end
            PRESSED: begin
                w_cnt   = '0;
                w_state = RELEASE;
            end
            RELEASE: if (w_tick) begin
                // any low row restarts the release count
                w_cnt = (r_row_s == 4'hF) ? w_cnt_inc : '0;
                if (r_row_s == 4'hF && w_cnt_inc == CW'(DEB_CNT)) begin
                    w_cnt     = '0;
                    w_state   = SCAN;
                    w_col_idx = r_col_idx + 2'd1;
                end
            end
            default: w_state = SCAN;
        endcase
    end

`ifdef KEYPAD_OPERAND_EN
    logic [3:0] r_tens, r_units;
    logic       r_op_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens     <= 4'd0;
            r_units    <= 4'd0;
            r_op_valid <= 1'b0;
        end else begin
            r_op_valid <= key_valid && r_key_code == 4'hF;
            if (key_valid && r_key_code <= 4'd9) begin
                r_tens  <= r_units;
                r_units <= r_key_code;
            end else if (key_valid && r_key_code == 4'hE) begin
                r_tens  <= 4'd0;
                r_units <= 4'd0;
            end
        end
    end

    assign operand  = 8'(r_tens) * 8'd10 + 8'(r_units);
    assign op_valid = r_op_valid;
`else
    assign operand  = 8'd0;
    assign op_valid = 1'b0;
`endif
endmodule
